// File: rtl/op1_sched_pkg.sv
// -----------------------------------------------------------------------------
// op1_sched_pkg
// Shared constants and types for the op1_sched round-robin scheduler.
//   OPW       operand width (X and Y)
//   RESW      result width (C)
//   NREQ_DEF  default number of requesters
//   state_e   scheduler FSM states
//   rr_next   wrap-around increment used by the round-robin pointer
// No ports (package).
// -----------------------------------------------------------------------------
package op1_sched_pkg;

    localparam int OPW      = 4;
    localparam int RESW     = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/op1_sched_if.sv
// -----------------------------------------------------------------------------
// op1_sched_if
// Request/response bundle between operand sources, the scheduler and the
// result consumer.
//   req_valid  per-requester operand valid       (master -> slave)
//   req_ready  per-requester accept, one-hot/0   (slave  -> master)
//   req_x      packed X operands, 4 bits each    (master -> slave)
//   req_y      packed Y operands, 4 bits each    (master -> slave)
//   rsp_valid  result available                  (slave  -> master)
//   rsp_ready  consumer accepts result           (master -> slave)
//   rsp_data   8-bit result                      (slave  -> master)
//   rsp_id     owning requester index            (slave  -> master)
//   busy       scheduler not idle                (slave  -> master)
// -----------------------------------------------------------------------------
interface op1_sched_if
    import op1_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [OPW*NREQ-1:0]  req_x;
    logic [OPW*NREQ-1:0]  req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [RESW-1:0]      rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/op1_sched_sq_sub_unit.sv
// -----------------------------------------------------------------------------
// sq_sub_unit
// Combinational square-minus datapath: c_o = h_i ? (x_i*x_i - y_i) mod 256 : 0
//   x_i  in  4  X operand
//   y_i  in  4  Y operand (zero-extended before subtraction)
//   h_i  in  1  enable; output forced to 0 when low
//   c_o  out 8  result, underflow wraps silently
// -----------------------------------------------------------------------------
module sq_sub_unit
    import op1_sched_pkg::*;
(
    input  logic [OPW-1:0]  x_i,
    input  logic [OPW-1:0]  y_i,
    input  logic            h_i,
    output logic [RESW-1:0] c_o
);

    logic [RESW-1:0] x_ext;
    logic [RESW-1:0] y_ext;
    logic [RESW-1:0] sq;

    assign x_ext = {{(RESW-OPW){1'b0}}, x_i};
    assign y_ext = {{(RESW-OPW){1'b0}}, y_i};
    // 15*15 = 225 fits in 8 bits, so the square never truncates.
    assign sq    = x_ext * x_ext;
    assign c_o   = h_i ? (sq - y_ext) : '0;

endmodule

// File: rtl/op1_sched.sv
// -----------------------------------------------------------------------------
// op1_sched
// Shares one sq_sub_unit among NREQ requesters. One requester is granted at a
// time in IDLE, the datapath is enabled for exactly one EXEC cycle, and the
// result is held in RESP until the consumer takes it.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of op1_sched_if (request/response handshakes, busy)
// Build option:
//   OP1_SCHED_RR_EN defined   : round-robin, pointer advances past last owner
//   OP1_SCHED_RR_EN undefined : fixed priority, lowest index wins, no pointer
//
// state | meaning
// IDLE  | arbitrate, assert req_ready for the winner, capture on handshake
// EXEC  | datapath enabled, result registered into rsp_data
// RESP  | rsp_valid high, wait for rsp_ready
// -----------------------------------------------------------------------------
module op1_sched
    import op1_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
)(
    input  logic        clk,
    input  logic        rst_n,
    op1_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EXEC = ST_EXEC;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]      state_q, state_d;
    logic [OPW-1:0]  x_q, x_d;
    logic [OPW-1:0]  y_q, y_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [RESW-1:0] data_q, data_d;
    logic            vld_q, vld_d;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic            any;
    logic [NREQ-1:0] grant_oh;
    logic            dp_en;
    logic [RESW-1:0] dp_c;

`ifdef OP1_SCHED_RR_EN
    logic [IDW-1:0]  ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Priority search starting at ptr and wrapping at NREQ-1. The sum is one
    // bit wider than the index so ptr+i never overflows before the wrap.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        win = '0;
        any = 1'b0;
        sum = '0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!any && bus.req_valid[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

    // req_ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        grant_oh = '0;
        if (rst_n && state_q == S_IDLE && any) begin
            grant_oh[win] = 1'b1;
        end
    end

    assign dp_en = (state_q == S_EXEC);

    sq_sub_unit u_sq_sub_unit (
        .x_i (x_q),
        .y_i (y_q),
        .h_i (dp_en),
        .c_o (dp_c)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        data_d  = data_q;
        vld_d   = vld_q;
`ifdef OP1_SCHED_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // any implies req_valid[win] and req_ready[win] are both high.
                if (any) begin
                    x_d     = bus.req_x[win*OPW +: OPW];
                    y_d     = bus.req_y[win*OPW +: OPW];
                    id_d    = win;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                data_d  = dp_c;
                vld_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
`ifdef OP1_SCHED_RR_EN
                    ptr_d   = IDW'(rr_next(int'(id_q), NREQ));
`endif
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
`ifdef OP1_SCHED_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
`ifdef OP1_SCHED_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_op1_sched.sv
// -----------------------------------------------------------------------------
// tb_op1_sched
// Self-checking bench for op1_sched (NREQ=4). A transaction-level model tracks
// the in-flight request, its age in cycles and the arbitration pointer; every
// cycle the DUT outputs are compared against it. Directed sections pin the
// model with hand-computed literals, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_op1_sched;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    op1_sched_if #(.NREQ(N)) bus ();

    op1_sched #(.NREQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    bit m_pend;
    int m_age;
    int m_data;
    int m_id;
    int m_ptr;

    int cyc = 0;
    int q_id[$];
    int q_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int m_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int m_calc(input int x, input int y);
        return (x * x - y) & 255;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_age  = 0;
        m_ptr  = 0;
    endtask

    // One clock cycle: compare just after the falling edge, advance the model
    // on the rising edge, return at the next falling edge.
    task automatic cycle();
        int g;
        logic [N-1:0] er;
        logic [N-1:0] hs;
        bit rv;
        #1;
        g  = m_grant(bus.req_valid, m_ptr);
        er = '0;
        if (rst_n && !m_pend && g >= 0) er[g] = 1'b1;
        rv = m_pend && (m_age >= 1);
        chk("req_ready", int'(bus.req_ready), int'(er));
        chk("rsp_valid", int'(bus.rsp_valid), int'(rv));
        chk("busy",      int'(bus.busy),      int'(m_pend));
        if (rv) begin
            chk("rsp_data", int'(bus.rsp_data), m_data);
            chk("rsp_id",   int'(bus.rsp_id),   m_id);
        end
        hs = bus.req_valid & bus.req_ready;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                q_id.push_back(i);
                q_cyc.push_back(cyc);
            end
        end
        if (!rst_n) begin
            model_reset();
        end else if (m_pend) begin
            if (m_age >= 1 && bus.rsp_ready) begin
                m_pend = 1'b0;
`ifdef OP1_SCHED_RR_EN
                m_ptr = (m_id + 1) % N;
`endif
            end else begin
                m_age++;
            end
        end else if (g >= 0) begin
            m_pend = 1'b1;
            m_age  = 0;
            m_id   = g;
            m_data = m_calc(int'(bus.req_x[4*g +: 4]), int'(bus.req_y[4*g +: 4]));
        end
        @(negedge clk);
    endtask

    task automatic set_ops(input int idx, input int x, input int y);
        bus.req_x[4*idx +: 4] = 4'(x);
        bus.req_y[4*idx +: 4] = 4'(y);
    endtask

    task automatic do_req(input int idx, input int x, input int y, input int exp);
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        set_ops(idx, x, y);
        bus.rsp_ready = 1'b1;
        cycle();
        bus.req_valid = '0;
        cycle();
        #1;
        chk("lit_rsp_valid", int'(bus.rsp_valid), 1);
        chk("lit_rsp_data",  int'(bus.rsp_data),  exp);
        chk("lit_rsp_id",    int'(bus.rsp_id),    idx);
        cycle();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        model_reset();

        // reset values with all requesters valid
        bus.req_valid = '1;
        #12;
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data",  int'(bus.rsp_data),  0);
        chk("rst_rsp_id",    int'(bus.rsp_id),    0);
        chk("rst_busy",      int'(bus.busy),      0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", int'(bus.req_ready), 1);

        // arbitration order with every requester valid
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ops(i, i + 1, i);
        q_id.delete();
        q_cyc.delete();
        for (int i = 0; i < 16; i++) cycle();
        chk("rr_count", int'(q_id.size() >= 5), 1);
        if (q_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
`ifdef OP1_SCHED_RR_EN
                chk("rr_order", q_id[k], k % N);
`else
                chk("rr_order", q_id[k], 0);
`endif
                if (k > 0) chk("rr_interval", q_cyc[k] - q_cyc[k-1], 3);
            end
        end
        bus.req_valid = '0;
        for (int i = 0; i < 3; i++) cycle();

        // single request and arithmetic edges
        do_req(2, 3, 5, 8'h04);
        do_req(0, 15, 0, 8'hE1);
        do_req(1, 0, 1, 8'hFF);
        do_req(3, 15, 15, 8'hD2);

        // backpressure: 7*7-9 = 40 held for 5 cycles
        bus.req_valid    = 4'b0010;
        set_ops(1, 7, 9);
        bus.rsp_ready    = 1'b0;
        cycle();
        bus.req_valid    = '1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_data",  int'(bus.rsp_data),  40);
            chk("bp_rsp_id",    int'(bus.rsp_id),    1);
            chk("bp_req_ready", int'(bus.req_ready), 0);
            chk("bp_busy",      int'(bus.busy),      1);
            cycle();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        cycle();
        #1;
        chk("bp_release_busy",  int'(bus.busy),      0);
        chk("bp_release_valid", int'(bus.rsp_valid), 0);

        // reset while in EXEC
        @(negedge clk);
        bus.req_valid = '1;
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rx_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rx_busy",      int'(bus.busy),      0);
        chk("rx_rsp_data",  int'(bus.rsp_data),  0);
        chk("rx_rsp_id",    int'(bus.rsp_id),    0);
        chk("rx_req_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rx_rel_ready", int'(bus.req_ready), 1);
        q_id.delete();
        q_cyc.delete();
        for (int i = 0; i < 4; i++) cycle();
        chk("rx_count", int'(q_id.size() >= 1), 1);
        if (q_id.size() >= 1) chk("rx_first_winner", q_id[0], 0);

        // randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            bus.req_valid = N'($urandom);
            bus.req_x     = (4*N)'($urandom);
            bus.req_y     = (4*N)'($urandom);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
